// File: rtl/clean_cycle_controller_if.sv
// Signal bundle between the key-input logic / mode FSM side (master) and
// the clean cycle controller (slave).
interface clean_cycle_controller_if #(
    parameter int unsigned MODE_WIDTH = 3,
    parameter int unsigned SEC_WIDTH  = 8
);
    logic [MODE_WIDTH-1:0] current_mode;
    logic                  clean_req;
    logic                  cancel_req;
    logic                  fan_run_sec;
    logic                  clean_mode_req;
    logic [SEC_WIDTH-1:0]  remaining_sec;
    logic                  busy;
    logic                  clean_done;
    logic                  clean_abort;
    logic                  remind;

    modport master (
        output current_mode, clean_req, cancel_req, fan_run_sec,
        input  clean_mode_req, remaining_sec, busy, clean_done, clean_abort, remind
    );

    modport slave (
        input  current_mode, clean_req, cancel_req, fan_run_sec,
        output clean_mode_req, remaining_sec, busy, clean_done, clean_abort, remind
    );
endinterface

// File: rtl/clean_cycle_controller.sv
// Sequences one hood self-clean cycle (IDLE/ENTER/RUN/DONE) with a seconds countdown.
// Define CLEAN_REMIND_EN to build the fan-usage counter that drives remind.
module clean_cycle_controller #(
    parameter int unsigned           MODE_WIDTH    = 3,
    parameter logic [MODE_WIDTH-1:0] CLEAN_CODE    = MODE_WIDTH'(3'b100),
    parameter int unsigned           TICKS_PER_SEC = 100000000,
    parameter int unsigned           CLEAN_SECS    = 180,
    parameter int unsigned           SEC_WIDTH     = 8,
    parameter int unsigned           ENTER_TIMEOUT = 1000,
    parameter int unsigned           REMIND_SECS   = 36000
) (
    input  logic                     clk,
    input  logic                     rstn,
    clean_cycle_controller_if.slave  bus
);

    localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned WW = (ENTER_TIMEOUT > 1) ? $clog2(ENTER_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTER = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [WW-1:0]        wait_cnt, wait_nxt;
    logic [TW-1:0]        tick_cnt, tick_nxt;
    logic [SEC_WIDTH-1:0] rem_q, rem_nxt;
    logic                 done_nxt, abort_nxt, req_nxt;
    logic                 mode_match;

    assign mode_match        = (bus.current_mode == CLEAN_CODE);
    assign bus.remaining_sec = rem_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state              <= IDLE;
            wait_cnt           <= '0;
            tick_cnt           <= '0;
            rem_q              <= '0;
            bus.clean_mode_req <= 1'b0;
            bus.busy           <= 1'b0;
            bus.clean_done     <= 1'b0;
            bus.clean_abort    <= 1'b0;
        end else begin
            state              <= state_nxt;
            wait_cnt           <= wait_nxt;
            tick_cnt           <= tick_nxt;
            rem_q              <= rem_nxt;
            bus.clean_mode_req <= req_nxt;
            bus.busy           <= req_nxt;
            bus.clean_done     <= done_nxt;
            bus.clean_abort    <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        tick_nxt  = tick_cnt;
        rem_nxt   = rem_q;
        done_nxt  = 1'b0;
        abort_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clean_req) begin
                    state_nxt = ENTER;
                    wait_nxt  = '0;
                end
            end
            ENTER: begin
                if (bus.cancel_req) begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                end else if (mode_match) begin
                    state_nxt = RUN;
                    rem_nxt   = SEC_WIDTH'(CLEAN_SECS);
                    tick_nxt  = '0;
                end else if (wait_cnt == WW'(ENTER_TIMEOUT - 1)) begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + WW'(1);
                end
            end
            RUN: begin
                if (bus.cancel_req || !mode_match) begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                end else if (tick_cnt == TW'(TICKS_PER_SEC - 1)) begin
                    tick_nxt = '0;
                    rem_nxt  = rem_q - SEC_WIDTH'(1);
                    if (rem_q == SEC_WIDTH'(1)) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    tick_nxt = tick_cnt + TW'(1);
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Countdown is only visible while running; every exit from RUN zeroes it.
        if (state_nxt != RUN) begin
            rem_nxt = '0;
        end
        req_nxt = (state_nxt == ENTER) || (state_nxt == RUN);
    end

`ifdef CLEAN_REMIND_EN
    localparam int unsigned UW = $clog2(REMIND_SECS + 1);

    logic [UW-1:0] usage, usage_nxt;

    // Completing a clean resets the usage; the clear beats a same-cycle fan pulse.
    always_comb begin
        usage_nxt = usage;
        if (done_nxt) begin
            usage_nxt = '0;
        end else if (bus.fan_run_sec && (usage != UW'(REMIND_SECS))) begin
            usage_nxt = usage + UW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            usage      <= '0;
            bus.remind <= 1'b0;
        end else begin
            usage      <= usage_nxt;
            bus.remind <= (usage_nxt == UW'(REMIND_SECS));
        end
    end
`else
    logic unused_remind;
    assign unused_remind = bus.fan_run_sec ^ (REMIND_SECS == 0);
    assign bus.remind    = 1'b0;
`endif

endmodule

// File: doc/clean_cycle_controller.md
# clean_cycle_controller

Sequences one self-clean cycle of the hood: it accepts a clean request, asks the mode FSM to enter clean mode, times a fixed-length clean run in whole seconds, and reports completion or abort. It sits between the key-input logic and the mode FSM, alongside the clean-mode event counters. It also raises a cleaning reminder once cumulative fan running time passes a threshold.

## Interface
- MODE_WIDTH, 3: width of the mode code.
- CLEAN_CODE, 3'b100: mode code meaning clean mode.
- TICKS_PER_SEC, 100000000: clk cycles per second.
- CLEAN_SECS, 180: clean run length in seconds, 1..2^SEC_WIDTH-1.
- SEC_WIDTH, 8: width of remaining_sec.
- ENTER_TIMEOUT, 1000: max cycles to wait for the mode FSM to enter clean mode.
- REMIND_SECS, 36000: fan-run seconds before remind asserts.
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- current_mode  in  MODE_WIDTH  mode currently applied by the mode FSM.
- clean_req  in  1  one-cycle pulse, start request.
- cancel_req  in  1  one-cycle pulse, abort request.
- fan_run_sec  in  1  one-cycle pulse per second the fan runs in a gear mode.
- clean_mode_req  out  1  level, asks the mode FSM to enter or hold clean mode.
- remaining_sec  out  SEC_WIDTH  seconds left in the run, 0 outside RUN.
- busy  out  1  high in ENTER or RUN.
- clean_done  out  1  one-cycle pulse on successful completion.
- clean_abort  out  1  one-cycle pulse on cancel, timeout or mode loss.
- remind  out  1  level, cleaning due.

## Operation
- States: IDLE, ENTER, RUN, DONE. All outputs registered.
- IDLE: on clean_req, go to ENTER, set clean_mode_req=1, and clear the wait counter.
- ENTER:
  - cancel_req: go to IDLE, pulse clean_abort.
  - Otherwise, current_mode==CLEAN_CODE: go to RUN, load remaining_sec=CLEAN_SECS, and clear the tick counter.
  - Otherwise, wait counter == ENTER_TIMEOUT-1: go to IDLE, pulse clean_abort.
  - Otherwise, increment the wait counter.
- RUN, in priority order:
  - cancel_req: go to IDLE, pulse clean_abort.
  - current_mode!=CLEAN_CODE: go to IDLE, pulse clean_abort.
  - Tick counter == TICKS_PER_SEC-1: wrap it to 0 and decrement remaining_sec. If remaining_sec was 1, go to DONE.
  - Otherwise, increment the tick counter.
- DONE: lasts one cycle with clean_done=1, then IDLE.
- clean_mode_req: 1 only in ENTER and RUN. It drops the same edge the state leaves RUN or ENTER.
- clean_req outside IDLE is ignored. cancel_req in IDLE or DONE is ignored.
- Tick counter width: $clog2(TICKS_PER_SEC). Wait counter width: $clog2(ENTER_TIMEOUT).
- remaining_sec is 0 in IDLE, ENTER and DONE.
- Reminder:
  - The usage counter, of width $clog2(REMIND_SECS+1), increments on fan_run_sec and saturates at REMIND_SECS.
  - remind = (usage == REMIND_SECS).
  - The counter clears only on the edge entering DONE. An abort does not clear it.
  - Clear wins over a simultaneous fan_run_sec.

## Timing
- Reset (rstn low at a rising edge) forces the following on that edge, regardless of state, including mid-run:
  - state=IDLE, usage=0, all counters 0;
  - clean_mode_req=0, remaining_sec=0, busy=0, clean_done=0, clean_abort=0, remind=0.
- clean_req sampled at edge n: clean_mode_req=1 and busy=1 from edge n.
- current_mode match sampled at edge m: RUN from edge m, with remaining_sec=CLEAN_SECS.
- RUN lasts exactly CLEAN_SECS*TICKS_PER_SEC cycles. remaining_sec decrements every TICKS_PER_SEC cycles.
- clean_done and clean_abort are never high together and last exactly one cycle.
- An ENTER timeout occurs after exactly ENTER_TIMEOUT cycles in ENTER without a match.

## Configuration
- Macro CLEAN_REMIND_EN.
- Defined: the reminder usage counter and remind output behave as above.
- Undefined: no usage counter is built, remind is tied 0, and fan_run_sec is ignored. The FSM is unchanged.

## Test plan
All scenarios use TICKS_PER_SEC=4, CLEAN_SECS=3, ENTER_TIMEOUT=5, REMIND_SECS=6.

1. Normal run:
   - Stimulus: clean_req; current_mode=CLEAN_CODE 2 cycles later, held.
   - Response: remaining_sec steps 3,2,1 every 4 cycles; clean_done pulses once after 12 RUN cycles; clean_mode_req low in DONE; clean_abort never high.
2. Enter timeout:
   - Stimulus: clean_req; current_mode never CLEAN_CODE.
   - Response: clean_abort after 5 ENTER cycles; clean_mode_req=0; busy=0.
3. Cancel and mode loss:
   - Stimulus: cancel_req at RUN cycle 6; in a second run, current_mode changes at RUN cycle 2.
   - Response: each case gives a one-cycle clean_abort, remaining_sec=0 and IDLE.
4. Reminder:
   - Stimulus: 7 fan_run_sec pulses, then a full clean run.
   - Response: remind rises after the 6th pulse and stays high; it clears on entering DONE. If CLEAN_REMIND_EN is undefined, remind stays 0.
5. Reset mid-run:
   - Stimulus: rstn=0 for 1 edge at RUN cycle 5.
   - Response: all outputs at reset values on that edge; a clean_req issued while in RUN before the reset was ignored.
